// File: rtl/clock_unit_pkg.sv
// clock_unit_pkg: shared state encoding, counter-width helper and saturation
// limit for the clock unit supervisor.
package clock_unit_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_e;

    localparam logic [7:0] CNT_SAT = 8'hFF;

    // Bits needed to hold the values 0 .. n-1 (at least one bit).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/clock_unit_sync.sv
// clock_unit_sync: two-flop synchroniser for asynchronous level inputs.
module clock_unit_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;

    // Shift the raw input through two stages.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchroniser flops; reset reads as "not locked".
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/clock_unit_supervisor.sv
// clock_unit_supervisor: pulses generator resets, waits for stable lock,
// releases domain resets in order and produces programmable clock-enable
// strobes while everything is locked. Defining CLOCK_UNIT_STATUS_EN builds
// the loss_cnt / retry_cnt status counters; otherwise they read 0.
module clock_unit_supervisor
    import clock_unit_pkg::*;
#(
    parameter int N_PLL         = 2,
    parameter int N_CE          = 2,
    parameter int DIV_W         = 8,
    parameter int RST_PULSE     = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int REL_GAP       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_PLL-1:0]      pll_locked,
    input  logic [N_CE*DIV_W-1:0] ce_div,
    output logic [N_PLL-1:0]      pll_rst,
    output logic [N_PLL-1:0]      dom_rst,
    output logic                  all_locked,
    output logic [N_CE-1:0]       ce_out,
    output logic [7:0]            loss_cnt,
    output logic [7:0]            retry_cnt
);

    localparam int REL_LEN = N_PLL * REL_GAP;
    localparam int MAX_A   = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
    localparam int MAX_B   = (STABLE_CYCLES > REL_LEN) ? STABLE_CYCLES : REL_LEN;
    localparam int CNT_W   = clog2((MAX_A > MAX_B) ? MAX_A : MAX_B);

    logic [N_PLL-1:0] locked_s;
    logic             lk_s;

    clock_unit_sync #(.W(N_PLL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    assign lk_s = &locked_s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_PLL-1:0] pll_rst_q, pll_rst_d;
    logic [N_PLL-1:0] dom_rst_q, dom_rst_d;
    logic             all_locked_q, all_locked_d;

    // Next state, shared phase counter and the outputs for the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            PLL_RST: begin
                if (cnt_q == CNT_W'(RST_PULSE - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (!lk_s) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(REL_LEN - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lk_s) begin
                    state_d = PLL_RST;
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase

        pll_rst_d    = {N_PLL{state_d == PLL_RST}};
        all_locked_d = (state_d == RUN);
        for (int i = 0; i < N_PLL; i++) begin
            dom_rst_d[i] = !((state_d == RUN) ||
                             ((state_d == RELEASE) && (cnt_d >= CNT_W'(i * REL_GAP))));
        end
    end

    // Supervisor state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            pll_rst_q    <= '1;
            dom_rst_q    <= '1;
            all_locked_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pll_rst_q    <= pll_rst_d;
            dom_rst_q    <= dom_rst_d;
            all_locked_q <= all_locked_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign dom_rst    = dom_rst_q;
    assign all_locked = all_locked_q;

`ifdef CLOCK_UNIT_STATUS_EN
    logic       loss_inc, retry_inc;
    logic [7:0] loss_q, loss_d;
    logic [7:0] retry_q, retry_d;

    // Saturating event counters for lock loss in RUN and lock timeouts.
    always_comb begin
        loss_inc  = (state_q == RUN) && !lk_s;
        retry_inc = (state_q == WAIT_LOCK) && !lk_s &&
                    (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
        loss_d    = loss_q;
        retry_d   = retry_q;
        if (loss_inc && (loss_q != CNT_SAT)) loss_d = loss_q + 8'd1;
        if (retry_inc && (retry_q != CNT_SAT)) retry_d = retry_q + 8'd1;
    end

    // Counter registers, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q  <= '0;
            retry_q <= '0;
        end else begin
            loss_q  <= loss_d;
            retry_q <= retry_d;
        end
    end

    assign loss_cnt  = loss_q;
    assign retry_cnt = retry_q;
`else
    assign loss_cnt  = '0;
    assign retry_cnt = '0;
`endif

    // Per-channel strobe: period counter counts 1..d within RUN, the ratio is
    // re-sampled whenever a period starts so mid-period edits wait a wrap.
    for (genvar k = 0; k < N_CE; k++) begin : g_ce
        logic [DIV_W-1:0] div_q, div_d;
        logic [DIV_W-1:0] pcnt_q, pcnt_d;
        logic             ce_q, ce_d;

        // Period bookkeeping and strobe for the next cycle.
        always_comb begin
            div_d  = div_q;
            pcnt_d = '0;
            ce_d   = 1'b0;
            if (state_d == RUN) begin
                if ((state_q != RUN) || (pcnt_q >= div_q)) begin
                    div_d  = ce_div[k*DIV_W +: DIV_W];
                    pcnt_d = DIV_W'(1);
                end else begin
                    pcnt_d = pcnt_q + DIV_W'(1);
                end
                ce_d = (div_d <= DIV_W'(1)) || (pcnt_d == div_d);
            end
        end

        // Strobe registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                div_q  <= '0;
                pcnt_q <= '0;
                ce_q   <= 1'b0;
            end else begin
                div_q  <= div_d;
                pcnt_q <= pcnt_d;
                ce_q   <= ce_d;
            end
        end

        assign ce_out[k] = ce_q;
    end

endmodule

// File: tb/tb_clock_unit_supervisor.sv
// tb_clock_unit_supervisor: scoreboard bench; a phase/time reference model
// predicts every cycle's outputs and a monitor compares them.
module tb_clock_unit_supervisor;

    localparam int N_PLL         = 2;
    localparam int N_CE          = 2;
    localparam int DIV_W         = 8;
    localparam int RST_PULSE     = 4;
    localparam int LOCK_TIMEOUT  = 64;
    localparam int STABLE_CYCLES = 16;
    localparam int REL_GAP       = 2;

    localparam int M_RST    = 0;
    localparam int M_WAIT   = 1;
    localparam int M_STABLE = 2;
    localparam int M_REL    = 3;
    localparam int M_RUN    = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_PLL-1:0]      pll_locked = '0;
    logic [N_CE*DIV_W-1:0] ce_div = '0;
    logic [N_PLL-1:0]      pll_rst;
    logic [N_PLL-1:0]      dom_rst;
    logic                  all_locked;
    logic [N_CE-1:0]       ce_out;
    logic [7:0]            loss_cnt;
    logic [7:0]            retry_cnt;

    typedef struct packed {
        logic [N_PLL-1:0] pll_rst;
        logic [N_PLL-1:0] dom_rst;
        logic             all_locked;
        logic [N_CE-1:0]  ce;
        logic [7:0]       loss;
        logic [7:0]       retry;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model state: phase, cycles spent in it, lock pipeline, counts.
    int   m_phase = M_RST;
    int   m_t     = 0;
    logic m_s1    = 1'b0;
    logic m_s2    = 1'b0;
    int   m_loss  = 0;
    int   m_retry = 0;
    int   m_d[N_CE];
    int   m_pend[N_CE];

    // Clock
    always #5 clk = ~clk;

    clock_unit_supervisor #(
        .N_PLL         (N_PLL),
        .N_CE          (N_CE),
        .DIV_W         (DIV_W),
        .RST_PULSE     (RST_PULSE),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .REL_GAP       (REL_GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .ce_div     (ce_div),
        .pll_rst    (pll_rst),
        .dom_rst    (dom_rst),
        .all_locked (all_locked),
        .ce_out     (ce_out),
        .loss_cnt   (loss_cnt),
        .retry_cnt  (retry_cnt)
    );

    // Advance the model by one clock using the inputs now being driven and
    // return what the outputs must show after that edge.
    function automatic exp_t model_step();
        exp_t e;
        logic lk;
        int   nt;
        int   run;
        if (rst) begin
            m_phase = M_RST;
            m_t     = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            m_loss  = 0;
            m_retry = 0;
        end else begin
            lk   = m_s2;
            m_s2 = m_s1;
            m_s1 = &pll_locked;
            nt   = m_t + 1;
            m_t  = nt;
            case (m_phase)
                M_RST:    if (nt == RST_PULSE) begin m_phase = M_WAIT; m_t = 0; end
                M_WAIT: begin
                    if (lk) begin
                        m_phase = M_STABLE; m_t = 0;
                    end else if (nt == LOCK_TIMEOUT) begin
                        m_phase = M_RST; m_t = 0;
                        if (m_retry < 255) m_retry++;
                    end
                end
                M_STABLE: begin
                    if (!lk) begin m_phase = M_WAIT; m_t = 0; end
                    else if (nt == STABLE_CYCLES) begin m_phase = M_REL; m_t = 0; end
                end
                M_REL: begin
                    if (!lk) begin m_phase = M_RST; m_t = 0; end
                    else if (nt == N_PLL * REL_GAP) begin m_phase = M_RUN; m_t = 0; end
                end
                default: begin
                    if (!lk) begin
                        m_phase = M_RST; m_t = 0;
                        if (m_loss < 255) m_loss++;
                    end
                end
            endcase
        end

        e.pll_rst    = (m_phase == M_RST) ? '1 : '0;
        e.all_locked = (m_phase == M_RUN);
        for (int i = 0; i < N_PLL; i++) begin
            if (m_phase == M_RUN) e.dom_rst[i] = 1'b0;
            else if (m_phase == M_REL) e.dom_rst[i] = (m_t < i * REL_GAP);
            else e.dom_rst[i] = 1'b1;
        end
        e.ce = '0;
        if (m_phase == M_RUN) begin
            run = m_t + 1;
            for (int k = 0; k < N_CE; k++) begin
                if (run == 1 || run > m_pend[k]) begin
                    m_d[k]    = int'(ce_div[k*DIV_W +: DIV_W]);
                    m_pend[k] = run + ((m_d[k] <= 1) ? 1 : m_d[k]) - 1;
                end
                e.ce[k] = (run == m_pend[k]);
            end
        end
`ifdef CLOCK_UNIT_STATUS_EN
        e.loss  = 8'(m_loss);
        e.retry = 8'(m_retry);
`else
        e.loss  = '0;
        e.retry = '0;
`endif
        return e;
    endfunction

    // Driver: apply one cycle of stimulus and queue the expected response.
    task automatic step(input logic r, input logic [N_PLL-1:0] pins);
        exp_t e;
        rst        = r;
        pll_locked = pins;
        e = model_step();
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    // Drive pins until the model reaches (phase, t), with a cycle budget.
    task automatic wait_model(input int phase, input int t, input logic [N_PLL-1:0] pins,
                              input string name);
        int budget;
        budget = 600;
        while (!(m_phase == phase && m_t == t) && budget > 0) begin
            step(1'b0, pins);
            budget--;
        end
        if (budget == 0) begin
            fails++;
            $display("FAIL wait_%s: phase %0d t %0d reached, required phase %0d t %0d",
                     name, m_phase, m_t, phase, t);
        end
    endtask

    // Scoreboard monitor: compare every presented cycle against the queue.
    always @(negedge clk) begin : mon
        exp_t e;
        exp_t a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pll_rst, dom_rst, all_locked, ce_out, loss_cnt, retry_cnt};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle_%0d: got pll_rst=%b dom_rst=%b all_locked=%b ce=%b loss=%0d retry=%0d, required pll_rst=%b dom_rst=%b all_locked=%b ce=%b loss=%0d retry=%0d",
                         cyc, a.pll_rst, a.dom_rst, a.all_locked, a.ce, a.loss, a.retry,
                         e.pll_rst, e.dom_rst, e.all_locked, e.ce, e.loss, e.retry);
            end
        end
    end

    // Stimulus sequence
    initial begin
        for (int k = 0; k < N_CE; k++) begin
            m_d[k]    = 0;
            m_pend[k] = 0;
        end
        ce_div = {8'd0, 8'd5};
        repeat (3) step(1'b1, 2'b00);

        // Nominal bring-up, locks appear at cycle 10; strobe ratio edit at RUN cycle 7.
        repeat (10) step(1'b0, 2'b00);
        wait_model(M_RUN, 5, 2'b11, "run_nominal");
        ce_div[7:0] = 8'd3;
        repeat (30) step(1'b0, 2'b11);

        // Lock loss in RUN, then full re-lock.
        repeat (3) step(1'b0, 2'b10);
        repeat (60) step(1'b0, 2'b11);

        // Persistent partial lock: repeated timeouts.
        repeat (3 * (RST_PULSE + LOCK_TIMEOUT) + 20) step(1'b0, 2'b01);

        // One-cycle glitch during STABLE.
        repeat (2) step(1'b1, 2'b11);
        wait_model(M_STABLE, 10, 2'b11, "stable10");
        step(1'b0, 2'b01);
        repeat (60) step(1'b0, 2'b11);

        // Reset in the middle of RELEASE after the first domain is out.
        repeat (4) step(1'b0, 2'b00);
        wait_model(M_REL, 1, 2'b11, "release1");
        step(1'b1, 2'b11);
        repeat (80) step(1'b0, 2'b11);

        // Randomised lock patterns, ratios and occasional resets.
        for (int it = 0; it < 60; it++) begin
            logic [1:0] pins;
            int         len;
            logic       r;
            pins = ($urandom_range(0, 2) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
            len  = $urandom_range(1, 50);
            r    = ($urandom_range(0, 19) == 0);
            ce_div = {8'($urandom_range(0, 9)), 8'($urandom_range(0, 9))};
            step(r, pins);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 15) == 0)
                    ce_div[7:0] = 8'($urandom_range(0, 9));
                step(1'b0, pins);
            end
        end

        // Long lockless stretch drives the retry counter into saturation.
        repeat (260 * (RST_PULSE + LOCK_TIMEOUT)) step(1'b0, 2'b10);
        repeat (50) step(1'b0, 2'b11);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
